// File: rtl/rx_udp_buffer_if.sv
// Bus bundle for rx_udp_buffer: UDP receive stream in, CPU read port and status out.
interface rx_udp_buffer_if #(
  parameter int OCT = 8
);
  logic           rx_udp_data_v;
  logic [OCT-1:0] rx_udp_data;
  logic           rd_en;
  logic           pkt_done;
  logic [OCT-1:0] rd_data;
  logic           rd_valid;
  logic [15:0]    rx_len;
  logic           pkt_ready;
  logic           rx_buf_irq;
  logic           ovf;

  modport master (
    output rx_udp_data_v, rx_udp_data, rd_en, pkt_done,
    input  rd_data, rd_valid, rx_len, pkt_ready, rx_buf_irq, ovf
  );

  modport slave (
    input  rx_udp_data_v, rx_udp_data, rd_en, pkt_done,
    output rd_data, rd_valid, rx_len, pkt_ready, rx_buf_irq, ovf
  );
endinterface

// File: rtl/rx_udp_buffer.sv
// Single-packet UDP receive buffer: captures one packet, holds it for CPU readout.
// Optional packet/drop counters enabled by defining RX_UDP_BUFFER_STATS_EN.
module rx_udp_buffer #(
  parameter int OCT   = 8,
  parameter int DEPTH = 2048
) (
  input  logic             RX_CLK,
  input  logic             rst,
  rx_udp_buffer_if.slave   bus
`ifdef RX_UDP_BUFFER_STATS_EN
  ,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [OCT-1:0] mem [DEPTH];

  logic [1:0]     state_q, state_d;
  logic           v_q;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCT-1:0] rd_data_q;
  logic           rd_valid_q, rd_valid_d;
  logic [15:0]    rx_len_q, rx_len_d;
  logic           pkt_ready_q, pkt_ready_d;
  logic           irq_q, irq_d;
  logic           ovf_q, ovf_d;
  logic           we, re;
  logic [AW-1:0]  waddr;
  logic           v;

  assign v = bus.rx_udp_data_v;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rx_len_d    = rx_len_q;
    pkt_ready_d = pkt_ready_q;
    ovf_d       = ovf_q;
    rd_valid_d  = 1'b0;
    irq_d       = 1'b0;
    we          = 1'b0;
    re          = 1'b0;
    waddr       = wr_ptr_q[AW-1:0];
    case (state_q)
      IDLE: begin
        // v_q high means we joined mid-packet, so the remainder is discarded
        if (v) begin
          if (!v_q) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = PW'(1);
            state_d  = RECV;
          end else begin
            state_d  = DROP;
          end
        end
      end
      RECV: begin
        if (v) begin
          if (wr_ptr_q < DEPTH_W) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end else begin
            ovf_d    = 1'b1;
            state_d  = DROP;
          end
        end else begin
          rx_len_d    = 16'(wr_ptr_q);
          pkt_ready_d = 1'b1;
          rd_ptr_d    = '0;
          irq_d       = 1'b1;
          state_d     = READY;
        end
      end
      READY: begin
        if (bus.pkt_done) begin
          pkt_ready_d = 1'b0;
          rd_ptr_d    = '0;
          state_d     = IDLE;
        end else if (bus.rd_en && (16'(rd_ptr_q) < rx_len_q)) begin
          re         = 1'b1;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + PW'(1);
        end
      end
      DROP: begin
        if (!v) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (we) mem[waddr] <= bus.rx_udp_data;
  end

  always_ff @(posedge RX_CLK) begin
    if (!rst) begin
      state_q     <= IDLE;
      v_q         <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rx_len_q    <= '0;
      pkt_ready_q <= 1'b0;
      irq_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (re) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      rd_valid_q  <= rd_valid_d;
      rx_len_q    <= rx_len_d;
      pkt_ready_q <= pkt_ready_d;
      irq_q       <= irq_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef RX_UDP_BUFFER_STATS_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  always_ff @(posedge RX_CLK) begin
    if (!rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (irq_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (state_q == DROP && !v) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rx_len     = rx_len_q;
  assign bus.pkt_ready  = pkt_ready_q;
  assign bus.rx_buf_irq = irq_q;
  assign bus.ovf        = ovf_q;

endmodule
